// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and constants for the branch-prediction update scheduler.
package bp_pkg;

  // Decrements that take a 2-bit saturating counter from 11 down to 00.
  localparam int CLEAR_PASSES = 3;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } sched_state_e;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Requester, clear-control and counter-table port bundle of the update scheduler.
interface bp_update_scheduler_if #(
  parameter int SIZE = 1
);
  logic            src0_valid;
  logic            src0_ready;
  logic [SIZE-1:0] src0_idx;
  logic            src0_taken;
  logic            src1_valid;
  logic            src1_ready;
  logic [SIZE-1:0] src1_idx;
  logic            src1_taken;
  logic            clear_req;
  logic            clearing;
  logic            clear_done;
  logic            ctr_modify;
  logic            ctr_is_increment;
  logic [SIZE-1:0] ctr_modify_idx;

  // Requester / control side.
  modport master (
    output src0_valid, src0_idx, src0_taken,
    output src1_valid, src1_idx, src1_taken,
    output clear_req,
    input  src0_ready, src1_ready, clearing, clear_done,
    input  ctr_modify, ctr_is_increment, ctr_modify_idx
  );

  // Scheduler side.
  modport slave (
    input  src0_valid, src0_idx, src0_taken,
    input  src1_valid, src1_idx, src1_taken,
    input  clear_req,
    output src0_ready, src1_ready, clearing, clear_done,
    output ctr_modify, ctr_is_increment, ctr_modify_idx
  );
endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// Small synchronous FIFO holding {idx, taken} updates for one requester.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int SIZE       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [SIZE-1:0]                 pushIdx,
  input  logic                            pushTaken,
  input  logic                            pop,
  output logic [SIZE-1:0]                 headIdx,
  output logic                            headTaken,
  output logic [cntWidth(FIFO_DEPTH)-1:0] count,
  output logic                            empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = cntWidth(FIFO_DEPTH);

  typedef struct packed {
    logic [SIZE-1:0] idx;
    logic            taken;
  } upd_t;

  upd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          full;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  assign headIdx   = mem[rdPtr].idx;
  assign headTaken = mem[rdPtr].taken;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= '{idx: pushIdx, taken: pushTaken};
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bp_update_scheduler.sv
// Serialises resolved-branch updates from two requesters, plus table clears,
// onto the single write port of the 2-bit counter table.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int SIZE       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  bp_update_scheduler_if.slave bus
);
  localparam int CW = cntWidth(FIFO_DEPTH);

  logic [CW-1:0]   count0, count1;
  logic            empty0, empty1;
  logic [SIZE-1:0] headIdx0, headIdx1;
  logic            headTaken0, headTaken1;
  logic            grant0, grant1;

  sched_state_e    state;
  logic [SIZE-1:0] clearIdx;
  logic [1:0]      phase;
  logic            clearDone;
  logic            rrPtr;      // 0 = src0 wins the next contested grant

  assign bus.src0_ready = (count0 != CW'(FIFO_DEPTH));
  assign bus.src1_ready = (count1 != CW'(FIFO_DEPTH));
  assign bus.clearing   = (state == CLEAR);
  assign bus.clear_done = clearDone;

  bp_update_fifo #(.SIZE(SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.src0_valid && bus.src0_ready),
    .pushIdx   (bus.src0_idx),
    .pushTaken (bus.src0_taken),
    .pop       (grant0),
    .headIdx   (headIdx0),
    .headTaken (headTaken0),
    .count     (count0),
    .empty     (empty0)
  );

  bp_update_fifo #(.SIZE(SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.src1_valid && bus.src1_ready),
    .pushIdx   (bus.src1_idx),
    .pushTaken (bus.src1_taken),
    .pop       (grant1),
    .headIdx   (headIdx1),
    .headTaken (headTaken1),
    .count     (count1),
    .empty     (empty1)
  );

  // Round-robin grant; a clear in progress or a fresh clear request blocks it.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN && !bus.clear_req) begin
      if (!empty0 && !empty1) begin
        grant0 = !rrPtr;
        grant1 = rrPtr;
      end else begin
        grant0 = !empty0;
        grant1 = !empty1;
      end
    end
  end

  // Table write port: clear decrements take priority over granted updates.
  always_comb begin
    bus.ctr_modify       = 1'b0;
    bus.ctr_is_increment = 1'b0;
    bus.ctr_modify_idx   = '0;
    if (state == CLEAR) begin
      bus.ctr_modify     = 1'b1;
      bus.ctr_modify_idx = clearIdx;
    end else if (grant0) begin
      bus.ctr_modify       = 1'b1;
      bus.ctr_is_increment = headTaken0;
      bus.ctr_modify_idx   = headIdx0;
    end else if (grant1) begin
      bus.ctr_modify       = 1'b1;
      bus.ctr_is_increment = headTaken1;
      bus.ctr_modify_idx   = headIdx1;
    end
  end

  // Clear sequencer and round-robin pointer; a new clear_req restarts the walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      clearIdx  <= '0;
      phase     <= '0;
      clearDone <= 1'b0;
      rrPtr     <= 1'b0;
    end else begin
      clearDone <= 1'b0;
      case (state)
        RUN: begin
          if (bus.clear_req) begin
            state    <= CLEAR;
            clearIdx <= '0;
            phase    <= '0;
          end else if (!empty0 && !empty1) begin
            rrPtr <= !rrPtr;
          end
        end
        CLEAR: begin
          if (bus.clear_req) begin
            clearIdx <= '0;
            phase    <= '0;
          end else if (phase == 2'(CLEAR_PASSES - 1)) begin
            phase <= '0;
            if (clearIdx == '1) begin
              state     <= RUN;
              clearDone <= 1'b1;
            end else begin
              clearIdx <= clearIdx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts every table write
// and per-cycle status; a monitor compares them against the scheduler.
module tb_bp_update_scheduler;
  localparam int SZ    = 2;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << SZ;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_update_scheduler_if #(.SIZE(SZ)) bus ();

  bp_update_scheduler #(.SIZE(SZ), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [SZ-1:0] idx;
    logic          taken;
  } upd_t;

  typedef struct packed {
    logic          inc;
    logic [SZ-1:0] idx;
  } wr_t;

  typedef struct packed {
    logic skip;
    logic clr;
    logic done;
    logic r0;
    logic r1;
  } st_t;

  // Reference model state
  upd_t q0[$];
  upd_t q1[$];
  int   clrOps[$];
  bit   rrM;
  bit   doneM;

  // Scoreboard queues
  wr_t  expWr[$];
  st_t  expSt[$];

  int nChecks = 0;
  int nErrors = 0;

  // Counter table attached to the write port
  logic [1:0] tbl [NENT];
  logic       preload = 1'b0;
  logic [1:0] preVal  = 2'b00;

  // Saturating 2-bit counters driven by the scheduler's write port.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NENT; i++) tbl[i] <= preVal;
    end else if (bus.ctr_modify === 1'b1) begin
      if (bus.ctr_is_increment && tbl[bus.ctr_modify_idx] != 2'b11)
        tbl[bus.ctr_modify_idx] <= tbl[bus.ctr_modify_idx] + 2'b01;
      else if (!bus.ctr_is_increment && tbl[bus.ctr_modify_idx] != 2'b00)
        tbl[bus.ctr_modify_idx] <= tbl[bus.ctr_modify_idx] - 2'b01;
    end
  end

  task automatic check(input string name, input int got, input int want);
    nChecks++;
    if (got != want) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: per-cycle status, plus one scoreboard pop per table write.
  always @(negedge clk) begin
    st_t s;
    wr_t w;
    #2;
    if (expSt.size() > 0) begin
      s = expSt.pop_front();
      if (!s.skip) begin
        check("clearing",   int'(bus.clearing),   int'(s.clr));
        check("clear_done", int'(bus.clear_done), int'(s.done));
        check("src0_ready", int'(bus.src0_ready), int'(s.r0));
        check("src1_ready", int'(bus.src1_ready), int'(s.r1));
        if (bus.ctr_modify !== 1'b0) begin
          if (expWr.size() == 0) begin
            check("unexpected_modify", int'(bus.ctr_modify), 0);
          end else begin
            w = expWr.pop_front();
            check("is_increment", int'(bus.ctr_is_increment), int'(w.inc));
            check("modify_idx",   int'(bus.ctr_modify_idx),   int'(w.idx));
          end
        end
      end
    end
  end

  // One cycle of stimulus; the model predicts this cycle's outputs and its next state.
  task automatic step(input bit r, input bit v0, input int i0, input bit t0,
                      input bit v1, input int i1, input bit t1, input bit clr,
                      output bit acc0, output bit acc1);
    st_t  s;
    wr_t  w;
    bit   haveOut;
    bit   lastClr;
    upd_t h;
    @(negedge clk);
    rst            = r;
    bus.src0_valid = v0;
    bus.src0_idx   = SZ'(i0);
    bus.src0_taken = t0;
    bus.src1_valid = v1;
    bus.src1_idx   = SZ'(i1);
    bus.src1_taken = t1;
    bus.clear_req  = clr;

    s.skip = r;
    s.clr  = (clrOps.size() > 0);
    s.done = doneM;
    s.r0   = (q0.size() != DEPTH);
    s.r1   = (q1.size() != DEPTH);
    expSt.push_back(s);

    haveOut = 0;
    lastClr = 0;
    w       = '0;
    if (clrOps.size() > 0) begin
      w.inc   = 1'b0;
      w.idx   = SZ'(clrOps.pop_front());
      haveOut = 1;
      lastClr = (clrOps.size() == 0);
    end else if (!clr) begin
      if (q0.size() > 0 && q1.size() > 0) begin
        h   = rrM ? q1.pop_front() : q0.pop_front();
        rrM = !rrM;
        haveOut = 1;
      end else if (q0.size() > 0) begin
        h = q0.pop_front();
        haveOut = 1;
      end else if (q1.size() > 0) begin
        h = q1.pop_front();
        haveOut = 1;
      end
      w.inc = h.taken;
      w.idx = h.idx;
    end
    if (haveOut && !r) expWr.push_back(w);

    acc0 = v0 && s.r0;
    acc1 = v1 && s.r1;
    if (acc0) q0.push_back('{idx: SZ'(i0), taken: t0});
    if (acc1) q1.push_back('{idx: SZ'(i1), taken: t1});

    doneM = lastClr && !clr;
    if (clr) begin
      clrOps.delete();
      for (int i = 0; i < NENT; i++)
        for (int p = 0; p < 3; p++) clrOps.push_back(i);
    end
    if (r) begin
      q0.delete();
      q1.delete();
      clrOps.delete();
      rrM   = 0;
      doneM = 0;
      acc0  = 0;
      acc1  = 0;
    end
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  initial begin
    bit a0, a1;
    int guard;
    rst = 1'b1;
    bus.src0_valid = 0; bus.src0_idx = '0; bus.src0_taken = 0;
    bus.src1_valid = 0; bus.src1_idx = '0; bus.src1_taken = 0;
    bus.clear_req  = 0;
    rrM = 0; doneM = 0;

    // Reset, zeroing the attached table
    preload = 1'b1; preVal = 2'b00;
    step(1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    preload = 1'b0;
    idle(1);
    check("reset_modify", int'(bus.ctr_modify), 0);

    // src0: three increments of idx 1 issued back-to-back
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0, 0, 0, 0, a0, a1);
    idle(3);
    check("tbl1_after_incs", int'(tbl[1]), 3);

    // Both sides contending every cycle: strict alternation
    for (int k = 0; k < 8; k++) step(0, 1, 0, 1, 1, 3, 0, 0, a0, a1);
    idle(10);

    // Full clear from all-11
    @(negedge clk); preload = 1'b1; preVal = 2'b11;
    @(negedge clk); preload = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(14);
    for (int i = 0; i < NENT; i++) check("tbl_cleared", int'(tbl[i]), 0);

    // Clear with src0 filling its FIFO; fifth entry held until a pop after clear
    step(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    for (int k = 0; k < 5; k++) begin
      guard = 0;
      a0 = 0;
      while (!a0 && guard < 40) begin
        step(0, 1, k % NENT, k[0], 0, 0, 0, 0, a0, a1);
        guard++;
      end
      check("push_accepted", int'(a0), 1);
    end
    idle(16);

    // Restart on a second clear_req in clearing cycle 5
    step(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(14);

    // Reset mid-clear with three entries queued on src1
    step(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, k, 1, 0, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    idle(1);
    check("post_rst_modify", int'(bus.ctr_modify), 0);
    check("post_rst_ready1", int'(bus.src1_ready), 1);
    idle(4);

    // Random traffic with occasional clears and resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, NENT-1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, NENT-1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), a0, a1);
    end
    idle(40);

    @(negedge clk);
    #4;
    check("leftover_writes", expWr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
